// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS time setter.
// Holds the FSM state encoding, per-digit wrap limits and cursor indices.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_EDIT       = 2'd0,
        ST_INC_DELAY  = 2'd1,
        ST_INC_REPEAT = 2'd2,
        ST_RUNNING    = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

    localparam logic [1:0] CUR_SEC_ONES = 2'd0;
    localparam logic [1:0] CUR_SEC_TENS = 2'd1;
    localparam logic [1:0] CUR_MIN_ONES = 2'd2;
    localparam logic [1:0] CUR_MIN_TENS = 2'd3;

    function automatic logic [3:0] digit_max(input logic [1:0] cur);
        return (cur == CUR_SEC_TENS || cur == CUR_MIN_TENS) ? DIGIT_MAX_TENS : DIGIT_MAX_ONES;
    endfunction

    // Out-of-range values (e.g. from an odd DEFAULT_TIME) also wrap to zero.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on a debounced button level.
// Zero latency (combinational pulse); a level held through reset gives no pulse.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= level;
        end else begin
            prev <= level;
        end
    end

    assign pulse = reset & level & ~prev;

endmodule

// File: rtl/time_setter.sv
// MM:SS start-time editor with cursor, auto-repeat increment and one-shot load.
// Outputs registered (one cycle after the triggering edge); no backpressure, busy only gates RUNNING exit.
module time_setter #(
    parameter logic [15:0] DEFAULT_TIME = 16'h0300,
    parameter int          REPEAT_DELAY = 500,
    parameter int          REPEAT_RATE  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_en,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_go,
    input  logic        busy,
    output logic [15:0] start_time,
    output logic [1:0]  cursor,
    output logic        load,
    output logic        editing
);

    import timer_pkg::*;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic sel_pulse, inc_pulse, go_pulse;

    edge_detect u_sel_edge (.clk(clk), .reset(reset), .level(btn_sel), .pulse(sel_pulse));
    edge_detect u_inc_edge (.clk(clk), .reset(reset), .level(btn_inc), .pulse(inc_pulse));
    edge_detect u_go_edge  (.clk(clk), .reset(reset), .level(btn_go),  .pulse(go_pulse));

    state_t               state_q, state_d;
    logic [3:0][3:0]      digits_q, digits_d;
    logic [1:0]           cursor_q, cursor_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 armed_q, armed_d;
    logic                 load_q, load_d;
    logic                 bump;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_EDIT;
            digits_q <= DEFAULT_TIME;
            cursor_q <= CUR_SEC_ONES;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cursor_q <= cursor_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            load_q   <= load_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cursor_d = cursor_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        load_d   = 1'b0;
        bump     = 1'b0;

        case (state_q)
            ST_EDIT: begin
                // A go edge on an all-zero time is treated as if it never happened.
                if (go_pulse && digits_q != '0) begin
                    load_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = ST_RUNNING;
                end else if (inc_pulse) begin
                    bump    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_INC_DELAY;
                end else if (sel_pulse) begin
                    cursor_d = cursor_q + 2'd1;
                end
            end
            ST_INC_DELAY: begin
                if (!btn_inc) begin
                    state_d = ST_EDIT;
                end else if (tick_en) begin
                    if (cnt_q == DELAY_LAST) begin
                        bump    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_INC_REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_INC_REPEAT: begin
                if (!btn_inc) begin
                    state_d = ST_EDIT;
                end else if (tick_en) begin
                    if (cnt_q == RATE_LAST) begin
                        bump  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUNNING: begin
                // Select cancels even if the countdown never raised busy.
                if (sel_pulse) begin
                    armed_d = 1'b0;
                    state_d = ST_EDIT;
                end else if (busy) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = ST_EDIT;
                end
            end
            default: begin
                state_d = ST_EDIT;
            end
        endcase

        if (bump) begin
            digits_d[cursor_q] = digit_inc(digits_q[cursor_q], digit_max(cursor_q));
        end
    end

    assign start_time = digits_q;
    assign cursor     = cursor_q;
    assign load       = load_q;
    assign editing    = (state_q != ST_RUNNING);

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter DEFAULT_TIME, 16'h0300, BCD MM:SS value loaded into the digits at reset (3:00).
REQ-002 Parameter REPEAT_DELAY, 500, tick_en pulses a held increment button must stay held before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, 100, tick_en pulses between auto-repeat increments.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 tick_en  in  1  one-cycle timebase strobe (1 kHz nominal).
REQ-007 btn_sel  in  1  debounced level; rising edge advances the cursor.
REQ-008 btn_inc  in  1  debounced level; rising edge or hold increments the cursor digit.
REQ-009 btn_go  in  1  debounced level; rising edge requests a load into the countdown.
REQ-010 busy  in  1  high while the downstream countdown is running.
REQ-011 start_time  out  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, feeds the countdown start_count inputs.
REQ-012 cursor  out  2  selected digit: 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
REQ-013 load  out  1  one-cycle pulse; start_time valid and stable on that cycle.
REQ-014 editing  out  1  high in EDIT, INC_DELAY and INC_REPEAT states.

Function
REQ-015 Rising edges of btn_sel, btn_inc and btn_go are detected internally against the previous-cycle level; a level held high through reset produces no edge.
REQ-016 The FSM has states EDIT, INC_DELAY, INC_REPEAT, RUNNING.
REQ-017 EDIT, btn_sel edge: cursor <= cursor+1 mod 4; state stays EDIT.
REQ-018 EDIT, btn_inc edge: cursor digit increments the same cycle; repeat counter clears; -> INC_DELAY.
REQ-019 Digit increment wraps at the per-digit max (sec_ones 9->0, sec_tens 5->0, min_ones 9->0, min_tens 5->0), with no carry into the neighbouring digit.
REQ-020 INC_DELAY: counter increments on tick_en; on the REPEAT_DELAY-th tick, digit increments, counter clears -> INC_REPEAT.
REQ-021 INC_REPEAT: on every REPEAT_RATE-th tick_en the digit increments and the counter clears.
REQ-022 INC_DELAY/INC_REPEAT: btn_inc low -> EDIT the next cycle with no further increment; btn_sel edges ignored.
REQ-023 EDIT, btn_go edge with start_time != 0: load high exactly one cycle -> RUNNING; with start_time == 0 the edge is ignored and load stays low.
REQ-024 Same-cycle edges in EDIT: btn_go beats btn_inc, which beats btn_sel; lower-priority edges are discarded, not queued.
REQ-025 btn_go edge in INC_DELAY/INC_REPEAT is ignored.
REQ-026 RUNNING: digits and cursor frozen; armed flag sets when busy seen high; busy low with armed set -> EDIT.
REQ-027 RUNNING: btn_sel edge cancels -> EDIT regardless of busy (guards against a countdown that never asserts busy).
REQ-028 Digits retain their last edited value across RUNNING so the same time can be reloaded.
REQ-029 Counter width is $clog2 of max(REPEAT_DELAY, REPEAT_RATE)+1; the counter never wraps.

Reset
REQ-030 reset low at a clk edge: start_time <= DEFAULT_TIME, cursor <= 0, load <= 0, state <= EDIT, editing <= 1, counter and armed cleared, edge-detect registers <= current button levels.
REQ-031 Reset mid-RUNNING or mid-repeat aborts immediately; no load pulse is generated on or after the reset cycle.

Structure
REQ-032 Package timer_pkg holds the state enum, the digit max constants (9, 5) and the cursor index constants.
REQ-033 One sub-module, edge_detect (rising-edge pulse, synchronous active-low reset), is instantiated three times.

Verification
REQ-034 Reset, then btn_sel edge x2, btn_inc edge x1 -> cursor 2, start_time 16'h0400, load 0.
REQ-035 cursor 1 at 5, btn_inc edge -> sec_tens 0, start_time[15:8] unchanged (no carry).
REQ-036 btn_inc held for 800 ticks at cursor 0 from 0 -> increments at 0, 500, 600, 700, 800 ticks; sec_ones ends at 5.
REQ-037 start_time 0000, btn_go edge -> no load. Set 0001, btn_go edge -> single load pulse; busy 1 then 0 -> editing 1, start_time 0001.
REQ-038 btn_go and btn_inc rising the same cycle in EDIT -> load pulse, digit unchanged, state RUNNING.
REQ-039 Reset asserted during INC_REPEAT, btn_inc still high -> start_time 0300, cursor 0, no increment until btn_inc falls and rises again.
